// File: rtl/pc_stack_sequencer.sv
// pc_stack_sequencer: program-counter sequencer with a hardware
// return-address stack for subroutine call/return.
//
// Operation priority per cycle: ld > call > ret > inc > hold. Lower-priority
// strobes in the same cycle have no effect and never raise an error flag.
// The fetch address "out" is a separate register loaded from pc_q when sel
// is high, so it always shows the pc_q value from before the same edge.
//
// Optional feature: define PC_REL_JMP_EN to add the "rel" input; when rel=1
// the ld/call target is pc_q + jmp (jmp taken as two's complement, wrapping).
//
// Control strobes are level-sampled on each rising clk edge; there is no
// valid/ready handshake, every strobe is consumed in the cycle it is seen.
module pc_stack_sequencer #(
  parameter int              ADDR_W      = 5,
  parameter int              STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              inc,
  input  logic              ld,
  input  logic              call,
  input  logic              ret,
`ifdef PC_REL_JMP_EN
  input  logic              rel,
`endif
  input  logic [ADDR_W-1:0] jmp,
  input  logic              clr_err,
  output logic [ADDR_W-1:0] out,
  output logic              full,
  output logic              empty,
  output logic              err_ovf,
  output logic              err_unf
);

  localparam int CNT_W = $clog2(STACK_DEPTH + 1);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] out_q, out_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
  logic [ADDR_W-1:0] stack_d [STACK_DEPTH];
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] ret_addr;
  logic [ADDR_W-1:0] pc_inc;

  // Stack occupancy flags come straight from the count register.
  assign full  = (cnt_q == CNT_W'(STACK_DEPTH));
  assign empty = (cnt_q == '0);

  assign out     = out_q;
  assign err_ovf = ovf_q;
  assign err_unf = unf_q;

  assign pc_inc = pc_q + ADDR_W'(1);

  // Jump/call target: absolute, or pc-relative when the option is built in.
`ifdef PC_REL_JMP_EN
  assign target = rel ? (pc_q + jmp) : jmp;
`else
  assign target = jmp;
`endif

  // Top-of-stack read: entry count-1, selected by comparison so the index
  // never needs to be narrower/wider than the count register.
  always_comb begin
    ret_addr = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (cnt_q == CNT_W'(i + 1)) ret_addr = stack_q[i];
    end
  end

  // Next-state: one prioritised pc/stack operation, sticky error update,
  // and fetch-address capture.
  always_comb begin
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    stack_d = stack_q;
    out_d   = sel ? pc_q : out_q;
    // Clear first; a new error later in this block overrides it (set wins).
    ovf_d   = clr_err ? 1'b0 : ovf_q;
    unf_d   = clr_err ? 1'b0 : unf_q;

    if (ld) begin
      pc_d = target;
    end else if (call) begin
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
          if (cnt_q == CNT_W'(i)) stack_d[i] = pc_inc;
        end
        cnt_d = cnt_q + CNT_W'(1);
        pc_d  = target;
      end
    end else if (ret) begin
      if (empty) begin
        unf_d = 1'b1;
      end else begin
        pc_d  = ret_addr;
        cnt_d = cnt_q - CNT_W'(1);
      end
    end else if (inc) begin
      pc_d = pc_inc;
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q  <= RESET_ADDR;
      out_q <= RESET_ADDR;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      pc_q    <= pc_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      stack_q <= stack_d;
    end
  end

endmodule

// File: tb/tb_pc_stack_sequencer.sv
// Testbench for pc_stack_sequencer (default build: ADDR_W=5, STACK_DEPTH=4,
// RESET_ADDR=0). Hand-computed vector table, directed async-reset sequence,
// then a randomised phase checked against a behavioural stack model.
module tb_pc_stack_sequencer;

  localparam int AW    = 5;
  localparam int DEPTH = 4;
  localparam int EW    = AW + 4;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          sel = 1'b0, inc = 1'b0, ld = 1'b0, call = 1'b0, ret = 1'b0;
  logic          clr_err = 1'b0;
  logic [AW-1:0] jmp = '0;
  logic [AW-1:0] out;
  logic          full, empty, err_ovf, err_unf;

  always #5 clk = ~clk;

  pc_stack_sequencer #(.ADDR_W(AW), .STACK_DEPTH(DEPTH), .RESET_ADDR('0)) dut (
    .clk(clk), .rst(rst), .sel(sel), .inc(inc), .ld(ld), .call(call),
    .ret(ret), .jmp(jmp), .clr_err(clr_err), .out(out), .full(full),
    .empty(empty), .err_ovf(err_ovf), .err_unf(err_unf)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    logic          s, i, l, c, r, cl;
    logic [AW-1:0] j;
    logic [EW-1:0] e;   // {out, full, empty, err_ovf, err_unf}
  } vec_t;

  vec_t          vecs[$];
  logic [EW-1:0] exp_q[$];
  int            checks   = 0;
  int            failures = 0;

  function automatic logic [EW-1:0] pack(input logic [AW-1:0] o, input logic f, e, ov, un);
    return {o, f, e, ov, un};
  endfunction

  task automatic add(input logic s, i, l, c, r, cl, input logic [AW-1:0] j,
                     input logic [AW-1:0] eo, input logic ef, ee, eov, eun);
    vec_t v;
    v.s = s; v.i = i; v.l = l; v.c = c; v.r = r; v.cl = cl; v.j = j;
    v.e = pack(eo, ef, ee, eov, eun);
    vecs.push_back(v);
  endtask

  task automatic compare(input string name, input logic [EW-1:0] act, input logic [EW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got out=%0d full=%0b empty=%0b ovf=%0b unf=%0b, expected out=%0d full=%0b empty=%0b ovf=%0b unf=%0b",
               name, act[EW-1:4], act[3], act[2], act[1], act[0],
               req[EW-1:4], req[3], req[2], req[1], req[0]);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic s, i, l, c, r, cl, input logic [AW-1:0] j);
    sel = s; inc = i; ld = l; call = c; ret = r; clr_err = cl; jmp = j;
  endtask

  // Drive one cycle's strobes, queue the expectation, sample #1 after the edge.
  task automatic step(input string name, input logic s, i, l, c, r, cl,
                      input logic [AW-1:0] j, input logic [EW-1:0] e);
    logic [EW-1:0] req;
    drive(s, i, l, c, r, cl, j);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s: scoreboard queue empty", name);
    end else begin
      req = exp_q.pop_front();
      compare(name, {out, full, empty, err_ovf, err_unf}, req);
    end
  endtask

  // ---------------- behavioural model for random phase ----------------
  logic [AW-1:0] m_pc, m_out;
  logic [AW-1:0] m_stk[$];
  logic          m_ovf, m_unf;

  function automatic logic [EW-1:0] model(input logic s, i, l, c, r, cl, input logic [AW-1:0] j);
    if (s) m_out = m_pc;
    if (cl) begin m_ovf = 1'b0; m_unf = 1'b0; end
    if (l) m_pc = j;
    else if (c) begin
      if (m_stk.size() == DEPTH) m_ovf = 1'b1;
      else begin m_stk.push_back(AW'(m_pc + 1)); m_pc = j; end
    end else if (r) begin
      if (m_stk.size() == 0) m_unf = 1'b1;
      else m_pc = m_stk.pop_back();
    end else if (i) m_pc = AW'(m_pc + 1);
    return pack(m_out, m_stk.size() == DEPTH, m_stk.size() == 0, m_ovf, m_unf);
  endfunction

  // ---------------- test ----------------
  initial begin
    //   s i l c r cl jmp   out f e ov un
    add(0,0,1,0,0,0, 30,   0, 0,1,0,0);  // ld 30
    add(1,1,0,0,0,0,  0,  30, 0,1,0,0);  // inc, publish 30
    add(1,1,0,0,0,0,  0,  31, 0,1,0,0);  // inc wraps to 0, publish 31
    add(1,0,0,0,0,0,  0,   0, 0,1,0,0);  // publish wrapped 0
    add(0,0,1,0,0,0,  3,   0, 0,1,0,0);  // ld 3
    add(0,0,0,1,0,0, 20,   0, 0,0,0,0);  // call 20, push 4
    add(1,1,0,0,0,0,  0,  20, 0,0,0,0);
    add(0,1,0,0,0,0,  0,  20, 0,0,0,0);  // pc 22
    add(1,0,0,0,0,0,  0,  22, 0,0,0,0);
    add(1,0,0,0,1,0,  0,  22, 0,1,0,0);  // ret -> 4
    add(1,0,0,0,0,0,  0,   4, 0,1,0,0);
    add(0,0,0,1,0,0,  1,   4, 0,0,0,0);  // push 5
    add(0,0,0,1,0,0,  2,   4, 0,0,0,0);  // push 2
    add(0,0,0,1,0,0,  3,   4, 0,0,0,0);  // push 3
    add(0,0,0,1,0,0,  4,   4, 1,0,0,0);  // push 4, full
    add(1,0,0,1,0,0,  9,   4, 1,0,1,0);  // overflow, pc stays 4
    add(1,0,0,0,0,0,  0,   4, 1,0,1,0);
    add(0,0,0,0,0,1,  0,   4, 1,0,0,0);  // clr_err
    add(0,0,0,1,0,1,  9,   4, 1,0,1,0);  // new error beats clear
    add(0,0,0,0,0,1,  0,   4, 1,0,0,0);
    add(1,0,0,0,1,0,  0,   4, 0,0,0,0);  // pop 4
    add(1,0,0,0,1,0,  0,   4, 0,0,0,0);  // pop 3
    add(1,0,0,0,1,0,  0,   3, 0,0,0,0);  // pop 2
    add(1,0,0,0,1,0,  0,   2, 0,1,0,0);  // pop 5
    add(1,0,0,0,0,0,  0,   5, 0,1,0,0);
    add(1,0,0,0,1,0,  0,   5, 0,1,0,1);  // underflow
    add(0,1,1,1,0,0, 12,   5, 0,1,0,1);  // ld wins over call/inc
    add(1,0,0,0,0,0,  0,  12, 0,1,0,1);
    add(0,0,0,0,0,1,  0,  12, 0,1,0,0);
    add(0,0,1,0,0,0,  5,  12, 0,1,0,0);
    add(1,0,1,0,0,0, 17,   5, 0,1,0,0);  // sel with ld shows old pc
    add(1,0,0,0,0,0,  0,  17, 0,1,0,0);
    add(0,0,1,0,1,0,  2,  17, 0,1,0,0);  // ld over ret: no underflow
    add(1,0,0,0,0,0,  0,   2, 0,1,0,0);
    add(1,0,0,1,1,0, 10,   2, 0,0,0,0);  // call over ret, push 3
    add(1,0,0,0,1,0,  0,  10, 0,1,0,0);
    add(1,0,0,0,0,0,  0,   3, 0,1,0,0);
    add(0,0,1,0,0,0, 31,   3, 0,1,0,0);
    add(0,0,0,1,0,0,  8,   3, 0,0,0,0);  // return address wraps to 0
    add(1,0,0,0,1,0,  0,   8, 0,1,0,0);
    add(1,0,0,0,0,0,  0,   0, 0,1,0,0);

    // Reset state, checked while held in reset.
    #2;
    compare("reset_state", {out, full, empty, err_ovf, err_unf}, pack('0, 0, 1, 0, 0));
    #5 rst = 1'b1;   // t=7, between edges

    for (int k = 0; k < vecs.size(); k++) begin
      step($sformatf("vec%0d", k), vecs[k].s, vecs[k].i, vecs[k].l, vecs[k].c,
           vecs[k].r, vecs[k].cl, vecs[k].j, vecs[k].e);
    end

    // Asynchronous reset mid-cycle with pc=7, out=7, one stack entry.
    step("pre_rst_ld",   1,0,1,0,0,0, 7, pack(0, 0, 1, 0, 0));
    step("pre_rst_sel",  1,0,0,0,0,0, 0, pack(7, 0, 1, 0, 0));
    step("pre_rst_call", 0,0,0,1,0,0, 7, pack(7, 0, 0, 0, 0));
    drive(0,0,0,0,0,0,0);
    #2 rst = 1'b0;
    #1 compare("async_reset", {out, full, empty, err_ovf, err_unf}, pack('0, 0, 1, 0, 0));
    @(negedge clk);
    rst = 1'b1;
    step("post_rst_sel", 1,0,0,0,0,0, 0, pack('0, 0, 1, 0, 0));

    // Random phase against the behavioural model (state now pc=0, out=0).
    m_pc = '0; m_out = '0; m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    for (int n = 0; n < 400; n++) begin
      logic s, i, l, c, r, cl;
      logic [AW-1:0] j;
      logic [EW-1:0] e;
      s  = ($urandom_range(0, 1) == 1);
      i  = ($urandom_range(0, 1) == 1);
      l  = ($urandom_range(0, 9) == 0);
      c  = ($urandom_range(0, 3) == 0);
      r  = ($urandom_range(0, 3) == 0);
      cl = ($urandom_range(0, 7) == 0);
      j  = AW'($urandom_range(0, (1 << AW) - 1));
      e  = model(s, i, l, c, r, cl, j);
      step($sformatf("rand%0d", n), s, i, l, c, r, cl, j, e);
    end

    if (exp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL leftover: %0d expectations never compared, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_stack_sequencer.md
Name: pc_stack_sequencer

Overview:
Parametrised program-counter sequencer for the simple RISC CPU. Generalises the PC to configurable address width and adds a hardware return-address stack for subroutine call/return. Holds an internal next-address register (pc_q) and a registered fetch address (out) that is published on sel. Sits between the control unit (inc/ld/call/ret/sel strobes) and instruction memory (out).

Parameters:
ADDR_W, 5, width of jmp, out and all stored addresses
STACK_DEPTH, 4, number of return-address entries (>=1)
RESET_ADDR, 0, value of pc_q and out after reset (ADDR_W bits)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
sel  input  1  publish pc_q onto out this cycle
inc  input  1  pc_q <= pc_q + 1
ld   input  1  pc_q <= jmp (absolute jump)
call input  1  push pc_q + 1, then pc_q <= jmp
ret  input  1  pop top of stack into pc_q
jmp  input  ADDR_W  jump/call target
clr_err input 1  clear sticky error flags
out  output ADDR_W  registered fetch address
full  output 1  stack count == STACK_DEPTH (combinational from count)
empty output 1  stack count == 0 (combinational from count)
err_ovf output 1  sticky: call attempted while full
err_unf output 1  sticky: ret attempted while empty

Behaviour:
- Reset (rst=0, async): pc_q=RESET_ADDR, out=RESET_ADDR, count=0, all stack entries=0, err_ovf=0, err_unf=0; full=0, empty=1. Release synchronous to state: first update on first rising edge with rst=1.
- out: if sel, out <= pc_q (value before this edge's pc_q update); else holds. sel is independent of the pc_q operation and may coincide with any of them.
- pc_q operation, one per cycle, priority ld > call > ret > inc > hold:
  - ld: pc_q <= jmp; stack untouched.
  - call, not full: stack[count] <= pc_q + 1 (mod 2^ADDR_W), count <= count+1, pc_q <= jmp.
  - call, full: no push, pc_q unchanged, err_ovf <= 1.
  - ret, not empty: pc_q <= stack[count-1], count <= count-1.
  - ret, empty: pc_q unchanged, count unchanged, err_unf <= 1.
  - inc: pc_q <= pc_q + 1, wraps 2^ADDR_W-1 -> 0.
- Lower-priority strobes in the same cycle are ignored (no side effects, no error flag).
- clr_err: both error flags <= 0, unless a new error occurs the same cycle (set wins).
- Stack is LIFO; count range 0..STACK_DEPTH; count width clog2(STACK_DEPTH+1).
- Latency: pc_q change visible on out after the next sel edge (2 edges from strobe to out minimum).
- Reset mid-operation: immediate clear of all state regardless of clock.

Optional Feature:
Macro PC_REL_JMP_EN. Defined: adds input rel (1 bit); when rel=1, ld and call targets become pc_q + jmp (jmp as two's-complement ADDR_W, result mod 2^ADDR_W); return address for call still pc_q + 1. Not defined: no rel port, targets are always absolute jmp.

Test Plan:
Reset: rst=0 asynchronously mid-cycle with pc_q=7 -> out=0, empty=1, full=0, errors 0 immediately.
Inc/wrap (ADDR_W=5): from pc_q=30, inc x2 with sel each cycle -> out sequence 30, 31, then pc_q=0; next sel out=0.
Call/ret: pc_q=3, call jmp=20 -> pc_q=20, stack top=4; inc x2 -> 22; ret -> pc_q=4, empty=1.
Overflow: STACK_DEPTH=4, 4 calls then 5th call jmp=9 -> full=1, pc_q unchanged, err_ovf=1; clr_err -> err_ovf=0.
Underflow/priority: empty stack, ret -> err_unf=1, pc_q unchanged; ld=1,call=1,inc=1 jmp=12 same cycle -> pc_q=12, count unchanged.
sel coincidence: pc_q=5, ld jmp=17 with sel=1 -> out=5 after edge; next sel -> out=17.
